// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Watchdog build option: WB_ARB_TIMEOUT_EN.
package wb_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  typedef logic [1:0] arb_grant_t;

  localparam arb_grant_t GNT_NONE = 2'b00;
  localparam arb_grant_t GNT_M0   = 2'b01;
  localparam arb_grant_t GNT_M1   = 2'b10;

  localparam logic [31:0] WB_ARB_ABORT_DATA = 32'hDEAD_BEEF;

  // Round-robin pick: on a tie the master that did not own the bus last wins.
  function automatic arb_grant_t arb_pick(
    input logic       req0,
    input logic       req1,
    input arb_grant_t last
  );
    arb_grant_t g;
    g = GNT_NONE;
    if (req0 && req1) begin
      g = (last == GNT_M0) ? GNT_M1 : GNT_M0;
    end else if (req0) begin
      g = GNT_M0;
    end else if (req1) begin
      g = GNT_M1;
    end
    return g;
  endfunction

endpackage

// File: rtl/wb_master_arbiter_watchdog.sv
// Wait-cycle counter for the arbiter; pulses abort_o for one cycle
// when the granted strobe has waited TIMEOUT_CYCLES without an ack.
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_CNT_W       = 8
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic busy_i,
  input  logic stb_i,
  input  logic ack_i,
  output logic abort_o
);

  localparam logic [TO_CNT_W-1:0] Limit =
    TO_CNT_W'(TIMEOUT_CYCLES);

  logic [TO_CNT_W-1:0] cnt_q;
  logic [TO_CNT_W-1:0] cnt_d;

  assign abort_o = busy_i && (cnt_q == Limit);

  always_comb begin
    cnt_d = cnt_q;
    if (!busy_i || ack_i || abort_o) begin
      cnt_d = '0;
    end else if (stb_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter, grant held per cyc window.
// Define WB_ARB_TIMEOUT_EN to build the missing-ack watchdog.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_CNT_W       = 8
) (
  input  logic        clk_i,
  input  logic        rst_n,

  input  logic [31:0] m0_wb_dat_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_we_i,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,

  input  logic [31:0] m1_wb_dat_i,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_we_i,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,

  output logic [31:0] s_wb_dat_o,
  output logic [31:0] s_wb_adr_o,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_we_o,
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,

  output logic [1:0]  grant_o,
  output logic        err_o
);

  if ((2 ** TO_CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cfg
    $error("TO_CNT_W too narrow for TIMEOUT_CYCLES");
  end

  arb_state_t state_q;
  arb_grant_t grant_q;
  arb_grant_t last_q;
  arb_grant_t pick;

  logic req0;
  logic req1;
  logic busy;
  logic sel0;
  logic sel1;
  logic gnt_cyc;
  logic gnt_stb;
  logic abort;

  assign req0 = m0_wb_cyc_i & m0_wb_stb_i;
  assign req1 = m1_wb_cyc_i & m1_wb_stb_i;
  assign pick = arb_pick(req0, req1, last_q);

  assign busy = (state_q == ARB_BUSY);
  assign sel0 = busy & grant_q[0];
  assign sel1 = busy & grant_q[1];

  assign grant_o = grant_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= GNT_NONE;
      last_q  <= GNT_M1;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (req0 || req1) begin
            grant_q <= pick;
            state_q <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (!gnt_cyc) begin
            last_q  <= grant_q;
            grant_q <= GNT_NONE;
            state_q <= ARB_IDLE;
          end
        end
      endcase
    end
  end

  // Request path follows the owner; idle drives an all-zero bus.
  always_comb begin
    gnt_cyc    = 1'b0;
    gnt_stb    = 1'b0;
    s_wb_dat_o = '0;
    s_wb_adr_o = '0;
    s_wb_sel_o = '0;
    s_wb_we_o  = 1'b0;
    unique case (1'b1)
      sel0: begin
        gnt_cyc    = m0_wb_cyc_i;
        gnt_stb    = m0_wb_stb_i;
        s_wb_dat_o = m0_wb_dat_i;
        s_wb_adr_o = m0_wb_adr_i;
        s_wb_sel_o = m0_wb_sel_i;
        s_wb_we_o  = m0_wb_we_i;
      end
      sel1: begin
        gnt_cyc    = m1_wb_cyc_i;
        gnt_stb    = m1_wb_stb_i;
        s_wb_dat_o = m1_wb_dat_i;
        s_wb_adr_o = m1_wb_adr_i;
        s_wb_sel_o = m1_wb_sel_i;
        s_wb_we_o  = m1_wb_we_i;
      end
      default: begin
      end
    endcase
  end

  assign s_wb_cyc_o = gnt_cyc & ~abort;
  assign s_wb_stb_o = gnt_stb & ~abort;

  always_comb begin
    m0_wb_ack_o = 1'b0;
    m0_wb_dat_o = '0;
    m1_wb_ack_o = 1'b0;
    m1_wb_dat_o = '0;
    unique case (1'b1)
      sel0: begin
        m0_wb_ack_o = s_wb_ack_i | abort;
        m0_wb_dat_o = abort ? WB_ARB_ABORT_DATA
                            : s_wb_dat_i;
      end
      sel1: begin
        m1_wb_ack_o = s_wb_ack_i | abort;
        m1_wb_dat_o = abort ? WB_ARB_ABORT_DATA
                            : s_wb_dat_i;
      end
      default: begin
      end
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic err_q;

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_CNT_W       (TO_CNT_W)
  ) u_wdog (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .busy_i  (busy),
    .stb_i   (gnt_stb),
    .ack_i   (s_wb_ack_i),
    .abort_o (abort)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q | abort;
`else
  assign abort = 1'b0;
  assign err_o = 1'b0;
`endif

endmodule
